ucie_ctl_sb_tx: RTL and testbench

//  Sideband config transmitter of the UCIe controller. Builds a 64-bit sideband message
//  (32-bit header + 32-bit data) from a local decode request and serializes it LSB-first in
//  N-bit beats on the config lane, qualified by o_pl_cfg_vld. It is the partner of the

---
 rtl/ucie_ctl_sb_pkg.sv | 39 +++
 rtl/ucie_ctl_sb_tx_serializer.sv | 45 ++++
 rtl/ucie_ctl_sb_tx.sv | 85 ++++++++
 tb/tb_ucie_ctl_sb_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared constants, frame layout and FSM state type for the UCIe sideband config transmitter.
package ucie_ctl_sb_pkg;

  localparam logic [4:0] OPC_WITH_DATA = 5'b11011;
  localparam logic [4:0] OPC_NO_DATA   = 5'b10010;
  localparam logic [2:0] SRCID         = 3'b010;
  localparam logic [2:0] DSTID         = 3'b110;
  localparam logic [4:0] MAX_DECODE    = 5'h0F;
  localparam logic [4:0] DEC_ADV_CAP   = 5'h01;

  localparam int unsigned OPC_LSB     = 0;
  localparam int unsigned SRCID_LSB   = 5;
  localparam int unsigned MSGCODE_LSB = 8;
  localparam int unsigned SUBCODE_LSB = 16;
  localparam int unsigned DSTID_LSB   = 24;
  localparam int unsigned DP_BIT      = 30;
  localparam int unsigned CP_BIT      = 31;
  localparam int unsigned DATA_LSB    = 32;

  typedef enum logic [1:0] {IDLE, WAIT_CRD, SEND} sb_state_e;

  function automatic logic [63:0] build_frame(input logic [4:0] decode, input logic [31:0] cap);
    logic [63:0] f;
    logic [31:0] data;
    f    = '0;
    data = (decode == DEC_ADV_CAP) ? cap : '0;
    f[OPC_LSB +: 5]     = (decode == DEC_ADV_CAP) ? OPC_WITH_DATA : OPC_NO_DATA;
    f[SRCID_LSB +: 3]   = SRCID;
    f[MSGCODE_LSB +: 8] = {3'b000, decode};
    f[SUBCODE_LSB +: 8] = 8'h00;
    f[DSTID_LSB +: 3]   = DSTID;
    f[DP_BIT]           = ^data;
    // Header parity covers everything below it, including DP.
    f[CP_BIT]           = ^f[30:0];
    f[DATA_LSB +: 32]   = data;
    return f;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_tx_serializer.sv
// Holds one 64-bit sideband frame and emits it LSB-first as 64/N registered beats.
module ucie_ctl_sb_tx_serializer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [63:0]  frame,
  input  logic         run,
  output logic         beat_vld,
  output logic [N-1:0] beat_data,
  output logic         last
);

  localparam int unsigned BEATS = 64 / N;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [63:0]   frame_q;
  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q   <= '0;
      cnt       <= '0;
      beat_vld  <= 1'b0;
      beat_data <= '0;
    end else begin
      if (load) begin
        frame_q <= frame;
        cnt     <= '0;
      end
      if (run) begin
        beat_vld  <= 1'b1;
        beat_data <= frame_q[cnt * N +: N];
        cnt       <= last ? '0 : cnt + 1'b1;
      end else begin
        beat_vld  <= 1'b0;
        beat_data <= '0;
      end
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_tx.sv
// Sideband config transmitter: request handshake, frame build, credit gating and serialization.
`ifndef NC
`define NC 8
`endif

module ucie_ctl_sb_tx
  import ucie_ctl_sb_pkg::*;
#(
  parameter int unsigned N        = `NC,
  parameter int unsigned CRD_INIT = 1,
  parameter int unsigned CRD_MAX  = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_lp_sb_valid,
  input  logic [4:0]   i_lp_sb_decode,
  input  logic [31:0]  i_lp_adv_cap_value,
  output logic         o_lp_sb_ready,
  input  logic         i_cfg_crd,
  output logic         o_pl_cfg_vld,
  output logic [N-1:0] o_pl_cfg,
  output logic         o_sb_tx_error,
  output logic         o_crd_overflow
);

  sb_state_e   state;
  logic [3:0]  credits;
  logic        accept;
  logic        supported;
  logic        start;
  logic        ser_last;
  logic [63:0] frame_new;

  assign accept    = i_lp_sb_valid & o_lp_sb_ready;
  assign supported = (i_lp_sb_decode <= MAX_DECODE);
  assign frame_new = build_frame(i_lp_sb_decode, i_lp_adv_cap_value);

  // A message consumes a credit on the cycle it leaves IDLE/WAIT_CRD for SEND.
  always_comb begin
    start = 1'b0;
    case (state)
      IDLE:     start = accept & supported & (credits != '0);
      WAIT_CRD: start = (credits != '0) | i_cfg_crd;
      default:  start = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      credits        <= 4'(CRD_INIT);
      o_lp_sb_ready  <= 1'b1;
      o_sb_tx_error  <= 1'b0;
      o_crd_overflow <= 1'b0;
    end else begin
      o_sb_tx_error  <= accept & ~supported;
      o_crd_overflow <= i_cfg_crd & ~start & (credits == 4'(CRD_MAX));
      if (i_cfg_crd & ~start & (credits != 4'(CRD_MAX)))
        credits <= credits + 4'd1;
      else if (start & ~i_cfg_crd)
        credits <= credits - 4'd1;
      o_lp_sb_ready <= ((state == IDLE) & ~accept) | ((state == SEND) & ser_last);
      case (state)
        IDLE:     if (accept & supported) state <= (credits != '0) ? SEND : WAIT_CRD;
        WAIT_CRD: if (start) state <= SEND;
        SEND:     if (ser_last) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  ucie_ctl_sb_tx_serializer #(
    .N(N)
  ) u_serializer (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (accept & supported),
    .frame     (frame_new),
    .run       (state == SEND),
    .beat_vld  (o_pl_cfg_vld),
    .beat_data (o_pl_cfg),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_ucie_ctl_sb_tx.sv
// Self-checking bench: transaction-level reference model plus directed literal checks and random traffic.
module tb_ucie_ctl_sb_tx;

  localparam int N        = 8;
  localparam int BEATS    = 64 / N;
  localparam int CRD_INIT = 1;
  localparam int CRD_MAX  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        crd = 1'b0;
  logic [4:0]  decode = '0;
  logic [31:0] cap = '0;
  logic        rdy, vld, err, ovf;
  logic [7:0]  data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ucie_ctl_sb_tx #(
    .N(N),
    .CRD_INIT(CRD_INIT),
    .CRD_MAX(CRD_MAX)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_lp_sb_valid      (valid),
    .i_lp_sb_decode     (decode),
    .i_lp_adv_cap_value (cap),
    .o_lp_sb_ready      (rdy),
    .i_cfg_crd          (crd),
    .o_pl_cfg_vld       (vld),
    .o_pl_cfg           (data),
    .o_sb_tx_error      (err),
    .o_crd_overflow     (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame computed arithmetically from the field rules.
  function automatic logic [63:0] model_frame(input logic [4:0] dec, input logic [31:0] c);
    logic [31:0] d, hdr;
    d   = (dec == 5'h01) ? c : 32'h0;
    hdr = ((dec == 5'h01) ? 32'd27 : 32'd18) + (32'd2 << 5) + (32'(dec) << 8) + (32'd6 << 24);
    if ($countones(d) % 2 == 1) hdr = hdr + 32'h4000_0000;
    if ($countones(hdr) % 2 == 1) hdr = hdr + 32'h8000_0000;
    return {d, hdr};
  endfunction

  // Reference model: credit count, one pending message, queue of beats still to appear.
  int          m_cred;
  bit          m_wait;
  bit          m_valid = 1'b0;
  logic [63:0] m_wframe, m_f;
  logic [7:0]  q[$];
  bit          acc, st;
  bit          e_rdy, e_vld, e_err, e_ovf;
  logic [7:0]  e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cred = CRD_INIT; m_wait = 1'b0; q.delete();
      e_rdy = 1'b1; e_vld = 1'b0; e_data = '0; e_err = 1'b0; e_ovf = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (q.size() > 0) begin e_vld = 1'b1; e_data = q.pop_front(); end
      else begin e_vld = 1'b0; e_data = '0; end
      acc = valid && e_rdy;
      st = 1'b0;
      e_err = 1'b0;
      if (acc && decode <= 5'h0F) begin
        m_f = model_frame(decode, cap);
        if (m_cred > 0) st = 1'b1;
        else begin m_wait = 1'b1; m_wframe = m_f; end
      end else if (acc) begin
        e_err = 1'b1;
      end else if (m_wait && (m_cred > 0 || crd)) begin
        st = 1'b1; m_f = m_wframe; m_wait = 1'b0;
      end
      if (st) for (int k = 0; k < BEATS; k++) q.push_back(m_f[k*N +: N]);
      e_ovf  = crd && !st && (m_cred == CRD_MAX);
      m_cred = m_cred + ((crd && !e_ovf) ? 1 : 0) - (st ? 1 : 0);
      e_rdy  = !acc && !m_wait && (q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_rdy", rdy, e_rdy);
      check("cyc_vld", vld, e_vld);
      check("cyc_data", data, e_data);
      check("cyc_err", err, e_err);
      check("cyc_ovf", ovf, e_ovf);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; crd = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [4:0] d, input logic [31:0] c);
    valid = 1'b1; decode = d; cap = c;
    tick();
    valid = 1'b0;
  endtask

  task automatic collect(input string nm, input logic [63:0] expf);
    int w;
    w = 0;
    while (vld !== 1'b1 && w < 20) begin tick(); w++; end
    check($sformatf("%s_latency", nm), w, 1);
    for (int k = 0; k < BEATS; k++) begin
      check($sformatf("%s_vld%0d", nm, k), vld, 1'b1);
      check($sformatf("%s_beat%0d", nm, k), data, expf[k*N +: N]);
      tick();
    end
  endtask

  task automatic expect_idle(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_novld%0d", nm, i), vld, 1'b0);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    check("model_frame_03", model_frame(5'h03, 32'h0), 64'h0000_0000_8600_0352);
    check("model_frame_01", model_frame(5'h01, 32'hA5A5_0001), 64'hA5A5_0001_C600_015B);

    // 1: plain message after reset
    do_reset();
    check("t1_ready", rdy, 1'b1);
    send(5'h03, 32'hDEAD_BEEF);
    check("t1_rdy_low", rdy, 1'b0);
    collect("t1", 64'h0000_0000_8600_0352);

    // 2: AdvCap message with payload
    do_reset();
    send(5'h01, 32'hA5A5_0001);
    collect("t2", 64'hA5A5_0001_C600_015B);

    // 3: no credits left, message waits for a credit return
    send(5'h05, 32'h1234_5678);
    expect_idle("t3", 5);
    crd = 1'b1; tick(); crd = 1'b0;
    collect("t3", model_frame(5'h05, 32'h0));

    // 4: unsupported decode rejected; credits still zero afterwards
    send(5'h12, 32'h0);
    check("t4_err", err, 1'b1);
    check("t4_rdy_low", rdy, 1'b0);
    check("t4_vld", vld, 1'b0);
    tick();
    check("t4_err_clr", err, 1'b0);
    check("t4_rdy_back", rdy, 1'b1);
    send(5'h02, 32'h0);
    expect_idle("t4", 3);
    crd = 1'b1; tick(); crd = 1'b0;
    collect("t4", 64'h0000_0000_0600_0252);

    // 5: credit saturation and overflow pulses, then four credits usable without waiting
    do_reset();
    for (int i = 0; i < 5; i++) begin
      crd = 1'b1; tick();
      check($sformatf("t5_ovf%0d", i), ovf, (i >= 3) ? 1'b1 : 1'b0);
    end
    crd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(5'(i + 4), 32'h0);
      collect($sformatf("t5_msg%0d", i), model_frame(5'(i + 4), 32'h0));
    end
    send(5'h09, 32'h0);
    expect_idle("t5_wait", 3);
    crd = 1'b1; tick(); crd = 1'b0;
    collect("t5_last", model_frame(5'h09, 32'h0));

    // 6: reset in the middle of a message
    do_reset();
    send(5'h03, 32'h0);
    w = 0;
    while (vld !== 1'b1 && w < 20) begin tick(); w++; end
    check("t6_start", w, 1);
    tick(); tick(); tick();
    check("t6_beat3", data, 8'h86);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_vld", vld, 1'b0);
    check("t6_rst_data", data, 8'h00);
    tick(); tick();
    rst = 1'b0;
    check("t6_rdy", rdy, 1'b1);
    expect_idle("t6", 3);
    send(5'h03, 32'h0);
    collect("t6_after", 64'h0000_0000_8600_0352);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      valid = ($urandom_range(0, 2) == 0);
      if (r < 2) decode = 5'h01;
      else if (r == 2) decode = 5'($urandom_range(16, 31));
      else decode = 5'($urandom_range(0, 15));
      cap = $urandom;
      crd = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      tick();
    end
    valid = 1'b0; crd = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
